// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller arbitrating instruction fetch and load/store on one 8-bit port.
// Optional MEM_CTRL_ROUND_ROBIN_EN: ties go to the requester not granted last.
module mem_ctrl #(
  parameter int unsigned RAM_ADDR_WIDTH = 17
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_req,
  input  logic [31:0]               if_addr,
  input  logic                      if_cancel,
  output logic [31:0]               if_data,
  output logic                      if_done,
  input  logic                      mem_req,
  input  logic                      mem_write,
  input  logic [1:0]                mem_len,
  input  logic [31:0]               mem_addr,
  input  logic [31:0]               mem_wdata,
  output logic [31:0]               mem_rdata,
  output logic                      mem_done,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic                      ram_wr,
  output logic [7:0]                ram_dout,
  input  logic [7:0]                ram_din,
  output logic                      busy
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic        owner_mem_q, owner_mem_d;
  logic [31:0] base_q, base_d;
  logic [2:0]  n_q, n_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;

  logic        grant_mem;
  logic [2:0]  len_n;
  logic [31:0] data_merged;
  logic [1:0]  rd_byte;
  logic [31:0] addr_sum;
  logic        unused_addr_hi;

`ifdef MEM_CTRL_ROUND_ROBIN_EN
  logic last_mem_q, last_mem_d;
  // On a tie, MEM wins only if IF was granted last.
  assign grant_mem = mem_req && (!if_req || !last_mem_q);
`else
  assign grant_mem = mem_req;
`endif

  always_comb begin
    unique case (mem_len)
      2'd0:    len_n = 3'd1;
      2'd1:    len_n = 3'd2;
      default: len_n = 3'd4;
    endcase
  end

  // Byte read at cnt = k+1 belongs to lane k.
  assign rd_byte = 2'(cnt_q - 3'd1);
  always_comb begin
    data_merged = data_q;
    data_merged[{rd_byte, 3'b000} +: 8] = ram_din;
  end

  always_comb begin
    state_d     = state_q;
    owner_mem_d = owner_mem_q;
    base_d      = base_q;
    n_d         = n_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
`ifdef MEM_CTRL_ROUND_ROBIN_EN
    last_mem_d  = last_mem_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (mem_req || if_req) begin
          state_d     = StBusy;
          owner_mem_d = grant_mem;
          base_d      = grant_mem ? mem_addr : if_addr;
          n_d         = grant_mem ? len_n : 3'd4;
          write_d     = grant_mem && mem_write;
          wdata_d     = mem_wdata;
          cnt_d       = 3'd0;
          data_d      = 32'd0;
`ifdef MEM_CTRL_ROUND_ROBIN_EN
          last_mem_d  = grant_mem;
`endif
        end
      end
      StBusy: begin
        cnt_d = cnt_q + 3'd1;
        if (!write_q && cnt_q != 3'd0) data_d = data_merged;
        if (!owner_mem_q && if_cancel) begin
          state_d = StIdle;
        end else if (write_q ? (cnt_q == n_q - 3'd1) : (cnt_q == n_q)) begin
          state_d = StDone;
          if (!write_q) begin
            if (owner_mem_q) mem_rdata_d = data_merged;
            else             if_data_d   = data_merged;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_mem_q <= 1'b0;
      base_q      <= 32'd0;
      n_q         <= 3'd0;
      write_q     <= 1'b0;
      wdata_q     <= 32'd0;
      cnt_q       <= 3'd0;
      data_q      <= 32'd0;
      if_data_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
`ifdef MEM_CTRL_ROUND_ROBIN_EN
      last_mem_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_mem_q <= owner_mem_d;
      base_q      <= base_d;
      n_q         <= n_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
`ifdef MEM_CTRL_ROUND_ROBIN_EN
      last_mem_q  <= last_mem_d;
`endif
    end
  end

  // Full 32-bit add so the address wraps before truncation to the RAM width.
  assign addr_sum       = base_q + {29'd0, cnt_q};
  assign unused_addr_hi = ^(addr_sum >> RAM_ADDR_WIDTH);

  always_comb begin
    ram_addr = '0;
    ram_wr   = 1'b0;
    ram_dout = 8'd0;
    if (state_q == StBusy) begin
      ram_addr = addr_sum[RAM_ADDR_WIDTH-1:0];
      ram_wr   = write_q && (cnt_q < n_q);
      ram_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
    end
  end

  assign busy      = (state_q != StIdle);
  assign if_done   = (state_q == StDone) && !owner_mem_q;
  assign mem_done  = (state_q == StDone) && owner_mem_q;
  assign if_data   = if_data_q;
  assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte-wide RAM model, scoreboard of expected completions.
// Covers fetch, store/load, tie arbitration, address wrap, cancel and mid-write reset.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_cancel = 1'b0;
  logic [31:0] if_data;
  logic        if_done;
  logic        mem_req = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  mem_len = 2'd0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic [16:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = 8'd0;
  logic        busy;

  mem_ctrl #(.RAM_ADDR_WIDTH(17)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_cancel (if_cancel),
    .if_data   (if_data),
    .if_done   (if_done),
    .mem_req   (mem_req),
    .mem_write (mem_write),
    .mem_len   (mem_len),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done),
    .ram_addr  (ram_addr),
    .ram_wr    (ram_wr),
    .ram_dout  (ram_dout),
    .ram_din   (ram_din),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:131071];

  // Synchronous-read RAM: read-before-write on the same edge.
  always @(posedge clk) begin
    ram_din <= ram[ram_addr];
    if (ram_wr) ram[ram_addr] = ram_dout;
  end

  int wr_cnt = 0;
  int if_done_cnt = 0;
  int mem_done_cnt = 0;
  bit cap_en = 1'b0;
  logic [16:0] addr_log[$];

  always @(negedge clk) begin
    if (ram_wr) wr_cnt++;
    if (if_done) if_done_cnt++;
    if (mem_done) mem_done_cnt++;
    if (cap_en && busy && !if_done && !mem_done) addr_log.push_back(ram_addr);
  end

  typedef struct {
    bit          is_mem;
    logic [31:0] data;
    int          lat;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit is_mem, input logic [31:0] data, input int lat, input string tag);
    exp_t e;
    e.is_mem = is_mem;
    e.data   = data;
    e.lat    = lat;
    e.tag    = tag;
    sb.push_back(e);
  endtask

  // Waits (bounded) for the next completion and checks it against the scoreboard head.
  task automatic wait_done(output bit owner_mem);
    int   k;
    exp_t e;
    k = 0;
    owner_mem = 1'b0;
    do begin
      step();
      k++;
    end while (!(if_done || mem_done) && k < 30);
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard underflow at time %0t", $time);
      return;
    end
    e = sb.pop_front();
    owner_mem = e.is_mem;
    check({e.tag, "_done"}, {31'd0, e.is_mem ? mem_done : if_done}, 32'd1);
    check({e.tag, "_other_done"}, {31'd0, e.is_mem ? if_done : mem_done}, 32'd0);
    check({e.tag, "_latency"}, 32'(k), 32'(e.lat));
    if (e.data !== 32'hxxxx_xxxx)
      check({e.tag, "_data"}, e.is_mem ? mem_rdata : if_data, e.data);
  endtask

  initial begin
    bit own;
    int wr_before;
    int ifd_before;
    int memd_before;
    logic [16:0] exp_addrs [5];

    for (int i = 0; i < 131072; i++) ram[i] = 8'd0;
    ram[17'h00100] = 8'h13; ram[17'h00101] = 8'h05;
    ram[17'h00102] = 8'h00; ram[17'h00103] = 8'h00;
    ram[17'h02000] = 8'h11; ram[17'h02001] = 8'h22;
    ram[17'h02002] = 8'h99; ram[17'h02003] = 8'h44;
    ram[17'h00010] = 8'h34; ram[17'h00011] = 8'h12; ram[17'h00012] = 8'h5A;
    ram[17'h00200] = 8'hEF; ram[17'h00201] = 8'hBE;
    ram[17'h00202] = 8'hAD; ram[17'h00203] = 8'hDE;
    ram[17'h1FFFE] = 8'hAA; ram[17'h1FFFF] = 8'hBB;
    ram[17'h00000] = 8'hCC; ram[17'h00001] = 8'hDD;

    // Reset state
    step();
    step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_if_done", {31'd0, if_done}, 32'd0);
    check("rst_mem_done", {31'd0, mem_done}, 32'd0);
    check("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_dout", 32'(ram_dout), 32'd0);
    check("rst_if_data", if_data, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    rst = 1'b0;
    step();

    // SB 0xAB to 0x2002, then LW 0x2000
    mem_req = 1'b1; mem_write = 1'b1; mem_len = 2'd0;
    mem_addr = 32'h2002; mem_wdata = 32'h0000_00AB;
    push(1'b1, 32'hxxxx_xxxx, 2, "sb");
    wait_done(own);
    mem_req = 1'b0; mem_write = 1'b0;
    step();
    check("sb_ram_byte", 32'(ram[17'h02002]), 32'h0000_00AB);
    mem_req = 1'b1; mem_len = 2'd2; mem_addr = 32'h2000;
    push(1'b1, 32'h44AB_2211, 6, "lw");
    wait_done(own);
    mem_req = 1'b0;
    step();

    // Fetch at 0x100, RAM must never be written
    wr_before = wr_cnt;
    if_req = 1'b1; if_addr = 32'h100;
    push(1'b0, 32'h0000_0513, 6, "fetch");
    wait_done(own);
    if_req = 1'b0;
    step();
    check("fetch_no_ram_wr", 32'(wr_cnt - wr_before), 32'd0);

    // Tie: LH 0x10 vs fetch 0x200; MEM then re-requests LB 0x12 to create a second tie
    mem_req = 1'b1; mem_write = 1'b0; mem_len = 2'd1; mem_addr = 32'h10;
    if_req = 1'b1; if_addr = 32'h200;
    push(1'b1, 32'h0000_1234, 4, "tie_lh");
`ifdef MEM_CTRL_ROUND_ROBIN_EN
    push(1'b0, 32'hDEAD_BEEF, 7, "tie_if");
    push(1'b1, 32'h0000_005A, 4, "tie_lb");
`else
    push(1'b1, 32'h0000_005A, 4, "tie_lb");
    push(1'b0, 32'hDEAD_BEEF, 7, "tie_if");
`endif
    for (int i = 0; i < 3; i++) begin
      wait_done(own);
      if (!own) if_req = 1'b0;
      else if (mem_len == 2'd1) begin
        mem_len = 2'd0;
        mem_addr = 32'h12;
      end else mem_req = 1'b0;
    end
    step();

    // Wrap and truncate: LW at 0xFFFFFFFE
    addr_log.delete();
    cap_en = 1'b1;
    mem_req = 1'b1; mem_len = 2'd2; mem_addr = 32'hFFFF_FFFE;
    push(1'b1, 32'hDDCC_BBAA, 6, "wrap_lw");
    wait_done(own);
    mem_req = 1'b0;
    cap_en = 1'b0;
    exp_addrs = '{17'h1FFFE, 17'h1FFFF, 17'h00000, 17'h00001, 17'h00002};
    check("wrap_addr_count", 32'(addr_log.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < addr_log.size()) check($sformatf("wrap_addr%0d", i), 32'(addr_log[i]),
                                     32'(exp_addrs[i]));
    step();

    // Cancel fetch at cnt=2 with a load pending behind it
    ifd_before = if_done_cnt;
    if_req = 1'b1; if_addr = 32'h300;
    step();
    mem_req = 1'b1; mem_len = 2'd0; mem_addr = 32'h12;
    step();
    step();
    check("cancel_busy_before", {31'd0, busy}, 32'd1);
    if_cancel = 1'b1; if_req = 1'b0;
    step();
    if_cancel = 1'b0;
    check("cancel_idle", {31'd0, busy}, 32'd0);
    check("cancel_no_if_done", {31'd0, if_done}, 32'd0);
    push(1'b1, 32'h0000_005A, 3, "post_cancel_lb");
    wait_done(own);
    mem_req = 1'b0;
    check("cancel_if_done_count", 32'(if_done_cnt - ifd_before), 32'd0);
    step();

    // Reset in the middle of a 4-byte store
    mem_req = 1'b1; mem_write = 1'b1; mem_len = 2'd2;
    mem_addr = 32'h4000; mem_wdata = 32'h1122_3344;
    step();
    step();
    check("sw_wr_cnt1", {31'd0, ram_wr}, 32'd1);
    memd_before = mem_done_cnt;
    rst = 1'b1;
    #1;
    check("rstmid_ram_wr", {31'd0, ram_wr}, 32'd0);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_ram_addr", 32'(ram_addr), 32'd0);
    check("rstmid_ram_dout", 32'(ram_dout), 32'd0);
    check("rstmid_mem_rdata", mem_rdata, 32'd0);
    check("rstmid_if_data", if_data, 32'd0);
    mem_req = 1'b0; mem_write = 1'b0;
    step();
    rst = 1'b0;
    repeat (3) step();
    check("rstmid_no_mem_done", 32'(mem_done_cnt - memd_before), 32'd0);
    check("rstmid_byte0_kept", 32'(ram[17'h04000]), 32'h0000_0044);
    check("rstmid_byte1_unwritten", 32'(ram[17'h04001]), 32'h0000_0000);
    check("sb_leftover", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
